// File: rtl/clk_divider_by8_counter.sv
// Free-running 2^CNT_W divider: count, terminal strobe and 50%-duty divided clock, all flop-driven.
// Optional CLKDIV_TAPS_EN adds div2_clk/div4_clk taps (registered count bits 0 and 1).
`timescale 1ns/100ps
module clk_divider_by8_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    output logic [CNT_W-1:0] o_count,
    output logic             o_count_end,
    output logic             div8_clk
`ifdef CLKDIV_TAPS_EN
    ,
    output logic             div2_clk,
    output logic             div4_clk
`endif
);

    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = o_count + CNT_W'(1);
    end

    // Strobe and divided clocks are loaded from count_next so they line up with o_count
    // while still coming straight out of their own flops.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            o_count     <= '0;
            o_count_end <= 1'b0;
            div8_clk    <= 1'b0;
        end else begin
            o_count     <= count_next;
            o_count_end <= (count_next == '1);
            div8_clk    <= count_next[CNT_W-1];
        end
    end

`ifdef CLKDIV_TAPS_EN
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            div2_clk <= 1'b0;
            div4_clk <= 1'b0;
        end else begin
            div2_clk <= count_next[0];
            div4_clk <= count_next[1];
        end
    end
`endif

endmodule

// File: tb/tb_clk_divider_by8_counter.sv
// Bench for clk_divider_by8_counter: time-based model of edges since reset release,
// checked every falling edge, plus literal checks at hand-picked instants.
`timescale 1ns/100ps
module tb_clk_divider_by8_counter;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] o_count;
    logic       o_count_end;
    logic       div8_clk;
`ifdef CLKDIV_TAPS_EN
    logic       div2_clk;
    logic       div4_clk;
`endif

    int n_cmp = 0;
    int n_err = 0;

    bit      in_reset = 1'b1;
    realtime t_rel    = 0.0;

    clk_divider_by8_counter #(.CNT_W(3)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .o_count     (o_count),
        .o_count_end (o_count_end),
        .div8_clk    (div8_clk)
`ifdef CLKDIV_TAPS_EN
        ,
        .div2_clk    (div2_clk),
        .div4_clk    (div4_clk)
`endif
    );

    // Rising edges at odd ns, falling edges at even ns.
    always #1 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $realtime);
        end
    endtask

    // Rising edges since release = odd integers in (t_rel, now].
    function automatic int edges_since_release();
        return int'($floor(($realtime + 1.0) / 2.0)) - int'($floor((t_rel + 1.0) / 2.0));
    endfunction

    always @(negedge clk) begin
        int k;
        int m;
        if (in_reset) begin
            check("cmp_count",  int'(o_count),     0);
            check("cmp_end",    int'(o_count_end), 0);
            check("cmp_div8",   int'(div8_clk),    0);
`ifdef CLKDIV_TAPS_EN
            check("cmp_div2",   int'(div2_clk),    0);
            check("cmp_div4",   int'(div4_clk),    0);
`endif
        end else begin
            k = edges_since_release();
            m = k % 8;
            check("cmp_count",  int'(o_count),     m);
            check("cmp_end",    int'(o_count_end), (m == 7) ? 1 : 0);
            check("cmp_div8",   int'(div8_clk),    (m >= 4) ? 1 : 0);
`ifdef CLKDIV_TAPS_EN
            check("cmp_div2",   int'(div2_clk),    m % 2);
            check("cmp_div4",   int'(div4_clk),    (m / 2) % 2);
`endif
        end
    end

    initial begin
        bit found;
        realtime t_evt;

        resetn   = 1'b1;
        in_reset = 1'b1;
        #10;
        check("hold_count", int'(o_count),     0);
        check("hold_end",   int'(o_count_end), 0);
        check("hold_div8",  int'(div8_clk),    0);
        #10;
        resetn   = 1'b0;
        t_rel    = $realtime;
        in_reset = 1'b0;

        #2;   // t=22: one edge after release
        check("first_count", int'(o_count), 1);
        #4;   // t=26
        check("t26_count", int'(o_count),  3);
        check("t26_div8",  int'(div8_clk), 0);
        #2;   // t=28
        check("t28_count", int'(o_count),  4);
        check("t28_div8",  int'(div8_clk), 1);
        #6;   // t=34
        check("t34_count", int'(o_count),     7);
        check("t34_end",   int'(o_count_end), 1);
        check("t34_div8",  int'(div8_clk),    1);
        #2;   // t=36: wrap
        check("wrap_count", int'(o_count),     0);
        check("wrap_end",   int'(o_count_end), 0);
        check("wrap_div8",  int'(div8_clk),    0);

        #4000;

        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk);
            if (o_count == 3'd5) found = 1'b1;
        end
        check("wait_count5", int'(found), 1);

        #0.5;
        resetn   = 1'b1;
        in_reset = 1'b1;
        #0.1;
        check("async_count", int'(o_count),     0);
        check("async_end",   int'(o_count_end), 0);
        check("async_div8",  int'(div8_clk),    0);
`ifdef CLKDIV_TAPS_EN
        check("async_div2",  int'(div2_clk),    0);
        check("async_div4",  int'(div4_clk),    0);
`endif
        #4.9;
        resetn   = 1'b0;
        t_rel    = $realtime;
        in_reset = 1'b0;
        t_evt    = $realtime;
        #2.5;
        check("restart_count", int'(o_count), 1);
        #8;
        check("restart_wrap", int'(o_count), 5);

        #200;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_divider_by8_counter.md
Name: clk_divider_by8_counter

Overview:
- Free-running 3-bit up-counter that divides the input clock by 8.
- Provides three outputs: the count, a terminal-count strobe, and a 50%-duty divided clock.
- Used as a clock-divider leaf block; its outputs feed downstream logic as a slow clock or enable.
- All outputs are driven directly from flops, so they are glitch-free.

Parameters:
- CNT_W, default 3: counter width. Division ratio is 2^CNT_W; the default gives divide-by-8.

Ports:
- clk  input  1  Sole clock. All state updates on its rising edge.
- resetn  input  1  Asynchronous reset, active-high: 1 = reset asserted. The name is kept for codebase consistency; it is not active-low.
- o_count  output  CNT_W  Current counter value.
- o_count_end  output  1  High for exactly one clk cycle while o_count == 2^CNT_W-1.
- div8_clk  output  1  Divided clock: period 2^CNT_W clk cycles, 50% duty.

Behaviour:
- Reset (resetn=1, asynchronous, takes effect immediately without a clk edge):
  - o_count = 0
  - o_count_end = 0
  - div8_clk = 0
  - Held for as long as resetn=1.
- Release: the first rising clk edge after resetn falls gives o_count = 1. There is no extra synchronizer cycle.
- Counting:
  - o_count increments by 1 on every rising edge.
  - Wraps from 7 to 0 (max to 0 in general) with no stall.
  - There is no enable; the counter is free-running.
- o_count_end:
  - Registered flop, set on the edge where the next count equals max, cleared on the following edge.
  - Equivalent to o_count == max, but driven from a flop.
  - Default: high for 1 cycle out of every 8.
- div8_clk:
  - Registered copy of the counter MSB: low for o_count 0..3, high for 4..7.
  - Rises on the edge that loads 4; falls on the edge that loads 0.
  - Period 8 clk cycles, duty exactly 50%.
- Reset mid-operation: all outputs return to their reset values immediately. Counting restarts from 0 after release; there is no partial-period carry-over.
- Wrap boundary: the transition max→0 coincides with o_count_end 1→0 and div8_clk 1→0 on the same edge.
- No X propagation: every flop has a reset value.

Optional Feature:
- Macro: CLKDIV_TAPS_EN.
- When defined, two additional outputs are added:
  - div2_clk, 1 bit: registered o_count[0]. Period 2 clk cycles.
  - div4_clk, 1 bit: registered o_count[1]. Period 4 clk cycles.
  - Both reset to 0, have 50% duty, and are phase-aligned so that all divided clocks are low when o_count = 0.
- When undefined, these ports and their flops do not exist. The behaviour of all other ports is unchanged in both cases.

Test Plan:
- Reset hold: clk period 2 ns, resetn=1 for 0–20 ns → o_count=0, o_count_end=0, div8_clk=0 throughout.
- Release and count: resetn=0 at 20 ns → o_count sequences 1,2,…,7,0,1,… on successive rising edges, with the first edge after release giving 1.
- Terminal strobe: free-run 4000 ns → o_count_end high exactly when o_count=7, for 1 cycle every 8 cycles, and never high for two consecutive cycles.
- Divided clock: free-run → div8_clk low for o_count 0–3 and high for 4–7. Period 16 ns, high time 8 ns, with no glitches between edges.
- Async reset mid-run: assert resetn=1 between clk edges while o_count=5 → all outputs go to 0 immediately. After deassertion the count restarts at 1.
- CLKDIV_TAPS_EN defined: free-run → div2_clk toggles every edge (period 4 ns) and div4_clk has period 8 ns. Both are 0 when o_count=0, and div8_clk is identical to the build without the macro.
